// File: rtl/e_mdu_pkg.sv
// Shared opcode encodings and default latencies for the multiply/divide unit.
// Also used by the controller and hazard unit.
package e_mdu_defs;

  localparam logic [3:0] MDU_none  = 4'd0;
  localparam logic [3:0] MDU_mult  = 4'd1;
  localparam logic [3:0] MDU_multu = 4'd2;
  localparam logic [3:0] MDU_div   = 4'd3;
  localparam logic [3:0] MDU_divu  = 4'd4;
  localparam logic [3:0] MDU_mfhi  = 4'd5;
  localparam logic [3:0] MDU_mflo  = 4'd6;
  localparam logic [3:0] MDU_mthi  = 4'd7;
  localparam logic [3:0] MDU_mtlo  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_launch(input logic [3:0] op);
    return (op == MDU_mult) || (op == MDU_multu) || (op == MDU_div) || (op == MDU_divu);
  endfunction

  function automatic logic is_divide(input logic [3:0] op);
    return (op == MDU_div) || (op == MDU_divu);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational 64-bit multiply/divide result generator.
// result_o is {hi, lo}; div_zero_o flags a divide whose divisor is zero.
module e_mdu_calc
  import e_mdu_defs::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] b_div_u;
  logic               b_zero;
  logic               div_ovf;

  assign prod_s = $signed({{32{src_a_i[31]}}, src_a_i}) * $signed({{32{src_b_i[31]}}, src_b_i});
  assign prod_u = {32'd0, src_a_i} * {32'd0, src_b_i};

  assign b_zero  = (src_b_i == 32'd0);
  assign div_ovf = (src_a_i == 32'h8000_0000) && (src_b_i == 32'hFFFF_FFFF);

  // Divisor is forced to 1 for /0 and INT_MIN/-1 so the dividers never see
  // an undefined case; INT_MIN/1 already yields the required quotient and 0 remainder.
  assign a_s     = $signed(src_a_i);
  assign b_s     = (b_zero || div_ovf) ? 32'sd1 : $signed(src_b_i);
  assign quot_s  = a_s / b_s;
  assign rem_s   = a_s % b_s;
  assign b_div_u = b_zero ? 32'd1 : src_b_i;

  always_comb begin
    result_o   = 64'd0;
    div_zero_o = 1'b0;
    case (op_i)
      MDU_mult:  result_o = prod_s;
      MDU_multu: result_o = prod_u;
      MDU_div: begin
        result_o   = {rem_s, quot_s};
        div_zero_o = b_zero;
      end
      MDU_divu: begin
        result_o   = {src_a_i % b_div_u, src_a_i / b_div_u};
        div_zero_o = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit: result latched at launch, committed to
// HI/LO after a fixed Busy window.
module e_mdu
  import e_mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Src_A,
  input  logic [31:0] Src_B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] MDUOut
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       temp_hi_q, temp_hi_d;
  logic [31:0]       temp_lo_q, temp_lo_d;
  logic              dz_q, dz_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic [63:0]       calc_result;
  logic              calc_div_zero;

  e_mdu_calc u_calc (
    .op_i       (MDUOp),
    .src_a_i    (Src_A),
    .src_b_i    (Src_B),
    .result_o   (calc_result),
    .div_zero_o (calc_div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (Start && is_launch(MDUOp)) begin
          state_d   = StBusy;
          temp_hi_d = calc_result[63:32];
          temp_lo_d = calc_result[31:0];
          dz_d      = calc_div_zero;
          cnt_d     = is_divide(MDUOp) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end else if (MDUOp == MDU_mthi) begin
          hi_d = Src_A;
        end else if (MDUOp == MDU_mtlo) begin
          lo_d = Src_A;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          // A divide by zero still spends the full window but leaves HI/LO alone.
          if (!dz_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy = (state_q == StBusy);

  always_comb begin
    MDUOut = 32'd0;
    case (MDUOp)
      MDU_mfhi: MDUOut = hi_q;
      MDU_mflo: MDUOut = lo_q;
      default:  MDUOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus randomized ops
// checked against an arithmetic HI/LO reference model.
module tb_e_mdu;
  import e_mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Src_A, Src_B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] MDUOut;

  int checks = 0;
  int errors = 0;

  // Reference architectural state
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  e_mdu dut (
    .clk    (clk),
    .reset  (reset),
    .Src_A  (Src_A),
    .Src_B  (Src_B),
    .MDUOp  (MDUOp),
    .Start  (Start),
    .Busy   (Busy),
    .MDUOut (MDUOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MDUOp = MDU_mfhi;
    #1 hi = MDUOut;
    MDUOp = MDU_mflo;
    #1 lo = MDUOut;
    MDUOp = MDU_none;
  endtask

  task automatic model_launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MDU_mult: begin
        p = longint'(sa * sb);
        {m_hi, m_lo} = p;
      end
      MDU_multu: begin
        p = ua * ub;
        {m_hi, m_lo} = p;
      end
      MDU_div: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      MDU_divu: if (b != 0) begin
        m_lo = 32'(ua / ub);
        m_hi = 32'(ua % ub);
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Start = 1'b0;
    MDUOp = MDU_none;
    tick();
    tick();
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] v);
    Src_A = v;
    MDUOp = op;
    tick();
    MDUOp = MDU_none;
    if (op == MDU_mthi) m_hi = v;
    else m_lo = v;
  endtask

  // stray: 0 quiet, 1 mtlo 0xDEADBEEF during Busy, 2 random Start/op traffic during Busy.
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stray, output int cycles,
                        output logic [31:0] busy_hi, output logic [31:0] busy_lo,
                        output logic [31:0] obs_hi, output logic [31:0] obs_lo);
    Src_A = a;
    Src_B = b;
    MDUOp = op;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    read_hilo(busy_hi, busy_lo);
    cycles = 0;
    while (Busy === 1'b1 && cycles < 100) begin
      if (stray == 1) begin
        MDUOp = MDU_mtlo;
        Src_A = 32'hDEAD_BEEF;
      end else if (stray == 2) begin
        Start = 1'($urandom_range(0, 1));
        MDUOp = 4'($urandom_range(1, 8));
        Src_A = $urandom;
        Src_B = $urandom;
      end
      tick();
      cycles++;
    end
    Start = 1'b0;
    MDUOp = MDU_none;
    read_hilo(obs_hi, obs_lo);
    model_launch(op, a, b);
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    do_reset();
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++;
    if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
  endtask

  task automatic test_mult();
    int cyc;
    logic [31:0] bh, bl, hi, lo;
    launch(MDU_mult, 32'hFFFF_FFFE, 32'd3, 0, cyc, bh, bl, hi, lo);
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL mult_cycles: got %0d want 5", cyc); end
    checks++;
    if (bh !== 32'd0 || bl !== 32'd0) begin
      errors++; $display("FAIL mult_busy_read: got %h/%h want 0/0", bh, bl);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_result: got %h/%h want ffffffff/fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    int cyc;
    logic [31:0] bh, bl, hi, lo;
    launch(MDU_div, 32'hFFFF_FFF9, 32'd2, 0, cyc, bh, bl, hi, lo);
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL div_cycles: got %0d want 10", cyc); end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_result: got %h/%h want ffffffff/fffffffd", hi, lo);
    end
    launch(MDU_divu, 32'hFFFF_FFF9, 32'd2, 0, cyc, bh, bl, hi, lo);
    checks++;
    if (hi !== 32'd1 || lo !== 32'h7FFF_FFFC) begin
      errors++; $display("FAIL divu_result: got %h/%h want 00000001/7ffffffc", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    logic [31:0] bh, bl, hi, lo;
    move_to(MDU_mthi, 32'h1234_5678);
    move_to(MDU_mtlo, 32'h9ABC_DEF0);
    launch(MDU_div, 32'd55, 32'd0, 1, cyc, bh, bl, hi, lo);
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL div0_cycles: got %0d want 10", cyc); end
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      errors++; $display("FAIL div0_keep: got %h/%h want 12345678/9abcdef0", hi, lo);
    end
  endtask

  task automatic test_abort();
    int cyc;
    logic [31:0] bh, bl, hi, lo;
    Src_A = 32'hFFFF_FFFF;
    Src_B = 32'hFFFF_FFFF;
    MDUOp = MDU_multu;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    MDUOp = MDU_none;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    read_hilo(hi, lo);
    checks++;
    if (Busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL abort_state: busy %b hi %h lo %h want 0/0/0", Busy, hi, lo);
    end
    // Nothing may land later from the aborted operation
    repeat (4) tick();
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL abort_late: got %h/%h want 0/0", hi, lo);
    end
    launch(MDU_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, bh, bl, hi, lo);
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++; $display("FAIL multu_result: got %h/%h want fffffffe/00000001", hi, lo);
    end
    reset = 1'b1;
    Start = 1'b1;
    MDUOp = MDU_mult;
    tick();
    reset = 1'b0;
    Start = 1'b0;
    MDUOp = MDU_none;
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_start: busy %b want 0", Busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] bh, bl, hi, lo;
    launch(MDU_mult, 32'd6, 32'd7, 0, cyc, bh, bl, hi, lo);
    launch(MDU_div, 32'd100, 32'd7, 0, cyc, bh, bl, hi, lo);
    checks++;
    if (bl !== 32'd42) begin errors++; $display("FAIL b2b_mid_lo: got %h want 2a", bl); end
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL b2b_cycles: got %0d want 10", cyc); end
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++; $display("FAIL b2b_result: got %h/%h want 2/e", hi, lo);
    end
    launch(MDU_div, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, bh, bl, hi, lo);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++; $display("FAIL div_ovf: got %h/%h want 0/80000000", hi, lo);
    end
  endtask

  task automatic test_random();
    int cyc, want;
    logic [3:0]  op;
    logic [31:0] a, b, bh, bl, hi, lo, old_hi, old_lo;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      if (is_launch(op)) begin
        old_hi = m_hi;
        old_lo = m_lo;
        want = is_divide(op) ? 10 : 5;
        launch(op, a, b, 2, cyc, bh, bl, hi, lo);
        checks++;
        if (cyc != want) begin
          errors++; $display("FAIL rnd_cycles op %0d: got %0d want %0d", op, cyc, want);
        end
        checks++;
        if (bh !== old_hi || bl !== old_lo) begin
          errors++; $display("FAIL rnd_busy_read op %0d: got %h/%h want %h/%h",
                             op, bh, bl, old_hi, old_lo);
        end
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
          errors++; $display("FAIL rnd_result op %0d a %h b %h: got %h/%h want %h/%h",
                             op, a, b, hi, lo, m_hi, m_lo);
        end
      end else if (op == MDU_mthi || op == MDU_mtlo) begin
        move_to(op, a);
        read_hilo(hi, lo);
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
          errors++; $display("FAIL rnd_move op %0d: got %h/%h want %h/%h", op, hi, lo, m_hi, m_lo);
        end
      end else begin
        Src_A = a;
        MDUOp = op;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
          errors++; $display("FAIL rnd_nolaunch op %0d: busy %b want 0", op, Busy);
        end
        checks++;
        if (MDUOut !== ((op == MDU_mfhi) ? m_hi : m_lo)) begin
          errors++; $display("FAIL rnd_read op %0d: got %h want %h", op, MDUOut,
                             (op == MDU_mfhi) ? m_hi : m_lo);
        end
        MDUOp = MDU_none;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    MDUOp = MDU_none;
    Src_A = 32'd0;
    Src_B = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multi-cycle multiply/divide unit for the execute stage, the sequential counterpart to the single-cycle ALU. It takes the same operand pair (Src_A, Src_B) and an opcode from the controller, and holds its results in architectural HI/LO registers. It reports a Busy window so the hazard unit can stall any later MDU instruction. Results are read back through a combinational output path (mfhi/mflo).

## Interface
- MULT_CYCLES, default 5: Busy cycles for mult/multu.
- DIV_CYCLES, default 10: Busy cycles for div/divu.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears HI, LO, Busy, counter.
- Src_A  in  32  rs operand: multiplicand, dividend, or mthi/mtlo data.
- Src_B  in  32  rt operand: multiplier or divisor.
- MDUOp  in  4  operation select, encodings in the shared package.
- Start  in  1  one-cycle pulse that launches mult/multu/div/divu.
- Busy  out  1  high while an operation is in flight.
- MDUOut  out  32  HI for mfhi, LO for mflo, else 0.

## Operation
- MDUOp encodings: none=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8. Codes 9–15 behave as none.
- The FSM has two states, IDLE and BUSY. Reset puts it in IDLE.
- IDLE to BUSY: Start=1 and MDUOp is one of mult/multu/div/divu.
  - On that edge the full result is computed from Src_A/Src_B and latched into internal temp_hi/temp_lo.
  - The counter loads MULT_CYCLES or DIV_CYCLES.
- In BUSY the counter decrements every edge. On the edge where the counter equals 1:
  - HI/LO take temp_hi/temp_lo.
  - The FSM returns to IDLE.
- Start in BUSY is ignored. The hazard unit guarantees it never happens; the unit must not corrupt state if it does.
- Start with a non-launch MDUOp is ignored.
- mthi/mtlo need no Start.
  - In IDLE, HI (or LO) takes Src_A on the edge where the op is presented.
  - In BUSY they are ignored.
- mult: {HI,LO} = signed(Src_A) * signed(Src_B), 64-bit. multu is the unsigned form.
- div: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend. divu is unsigned.
- Divide by zero (div or divu):
  - The operation still runs the full DIV_CYCLES with Busy asserted.
  - HI/LO keep their previous values.
- div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- MDUOut is purely combinational: mfhi returns the current HI, mflo returns the current LO, every other op returns 0.
- mfhi/mflo in BUSY return the old HI/LO; the hazard unit is responsible for stalling these.

## Timing
- Reset values: HI=0, LO=0, Busy=0, counter=0, state=IDLE. Hence MDUOut=0 after reset.
- Start sampled at edge t0:
  - Busy=1 from t0 through edge t0+N, where N = MULT_CYCLES or DIV_CYCLES.
  - Busy=0 after edge t0+N.
  - New HI/LO are visible on MDUOut immediately after edge t0+N.
- Busy is a registered output; Busy is low in the cycle Start is asserted. The stall logic ORs Start and Busy.
- A second Start is accepted at edge t0+N+1 (back-to-back operation, no dead cycle).
- mthi/mtlo take effect on the edge they are presented; mfhi in the next cycle returns the new value.
- reset during BUSY aborts the operation. The pending temp result is discarded and HI=LO=0 after the reset edge.
- reset and Start on the same edge: reset wins and the unit stays in IDLE.

## Structure
- Shared package e_mdu_defs holds:
  - MDU_none … MDU_mtlo opcode constants (4-bit).
  - MULT_CYCLES/DIV_CYCLES defaults.
- The controller and hazard unit include the same package.
- One sub-module, e_mdu_calc: purely combinational 64-bit result generation from op/Src_A/Src_B, including the divide-by-zero flag.
- The parent e_mdu holds the FSM, counter, temp registers and HI/LO.

## Test plan
- reset, then mfhi and mflo: MDUOut=0 for both, Busy=0.
- Signed multiply: mult Src_A=0xFFFFFFFE (-2), Src_B=3, Start=1.
  - Busy stays high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - mfhi/mflo during BUSY return the old values (0).
- Signed divide: div Src_A=0xFFFFFFF9 (-7), Src_B=2.
  - Busy stays high for 10 cycles.
  - Then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - A divu with the same operands gives LO=0x7FFFFFFC, HI=1.
- Divide by zero: mthi 0x12345678, mtlo 0x9ABCDEF0, then div by 0.
  - Busy stays high for 10 cycles.
  - HI/LO are unchanged afterwards.
  - A mtlo issued during BUSY is ignored.
- Abort on reset: multu 0xFFFFFFFF × 0xFFFFFFFF, assert reset at cycle 3 of BUSY.
  - Busy=0 and HI=LO=0 after the reset edge.
  - Re-issuing the multu without reset gives HI=0xFFFFFFFE, LO=0x00000001.
- Back-to-back launches: mult 6×7 is immediately followed by Start of div 100/7 on edge t0+6.
  - The div is accepted.
  - Final result: LO=14, HI=2.
  - An intermediate mflo before the div completes shows 42.
